cache_sdram_bridge: RTL and testbench
=====================================

// Module: cache_sdram_bridge
// PURPOSE
//  Sits directly downstream of the direct-mapped cache's SDRAM port, in front of the SDRAM controller.
//  Queues CPU write-through stores in a small FIFO and splits each 32-bit store into two 16-bit writes.
//  Issues cache line-fill reads and returns their 8-halfword burst in the cache's fill timing.
//  Drains all queued writes before any fill, so a refill always sees prior stores.
// PARAMETERS
//  WRQ_LOG2   2   log2 of write-queue depth (4 entries of addr+data+bytesel)
//  BURSTLEN   8   halfwords per fill burst (fixed; cache line = 4 x 32-bit words)
// PORTS
//  clk            in   1   system clock; all logic on rising edge
//  reset          in   1   asynchronous, active-low reset
//  cache_addr     in   32  fill address from cache (critical word in [3:2])
//  cache_req      in   1   fill request; level, held until cache_fill
//  data_to_cache  out  16  fill halfword, high half of each word first
//  cache_fill     out  1   one-cycle strobe coincident with first fill halfword
//  wr_addr        in   32  CPU store address
//  wr_data        in   32  CPU store data
//  wr_bytesel     in   4   byte enables; [3] = bits 31:24
//  wr_req         in   1   store request
//  wr_ack         out  1   one-cycle pulse: store accepted into queue
//  wr_pending     out  1   queue non-empty or write in flight
//  sd_addr        out  32  controller address, [0] always 0
//  sd_req         out  1   command request; held until sd_ack
//  sd_wr          out  1   1 = write command, 0 = read burst
//  sd_ack         in   1   controller accepted command (one cycle)
//  sd_wdata       out 16   write halfword
//  sd_dqm         out  2   byte mask, 1 = masked (= ~bytesel pair)
//  sd_wnext       in   1   controller consumed current write halfword
//  sd_rdata       in  16   read burst data
//  sd_rvalid      in   1   read data valid; BURSTLEN contiguous cycles per burst
//  burst_error    out  1   sticky: sd_rvalid dropped mid-burst; cleared only by reset
// BEHAVIOUR
//  Reset values: sd_req=0, sd_wr=0, wr_ack=0, cache_fill=0, burst_error=0, data_to_cache=0,
//   sd_wdata=0, sd_dqm=2'b11; queue empty; FSM in IDLE. Reset mid-op abandons everything.
//  Queue:
//   - wr_ack pulses the cycle after wr_req is sampled with queue not full.
//   - Requester drops wr_req on wr_ack; a held wr_req produces one entry per ack.
//   - Full: wr_req waits, no ack.
//   - Push and pop in the same cycle are legal, including when full.
//   - Pointers wrap mod 2**WRQ_LOG2.
//  FSM states: IDLE, WR_CMD, WR_HI, WR_LO, RD_CMD, RD_BURST.
//   IDLE: queue non-empty -> WR_CMD (writes take priority); else cache_req -> RD_CMD.
//   WR_CMD: sd_req=1, sd_wr=1, sd_addr={head.addr[31:2],2'b00}; sd_ack -> WR_HI.
//   WR_HI: sd_wdata=data[31:16], sd_dqm=~bytesel[3:2]; sd_wnext -> WR_LO.
//   WR_LO: sd_wdata=data[15:0], sd_dqm=~bytesel[1:0]; sd_wnext -> pop -> IDLE.
//   RD_CMD: sd_req=1, sd_wr=0, sd_addr={cache_addr[31:2],2'b00}; sd_ack -> RD_BURST.
//    The controller wraps the burst within the 16-byte line, starting at addr[3:1].
//   RD_BURST: 3-bit counter; each sd_rvalid registers sd_rdata into data_to_cache (1-cycle latency).
//    cache_fill pulses with halfword 0 only; the cache counts the remaining 7.
//    After 8 beats -> IDLE. Writes arriving mid-burst queue and wait.
//  Gaps: sd_rvalid low mid-burst sets burst_error, and the counter resumes on the next sd_rvalid.
//  sd_req drops the cycle after sd_ack. At most one controller command is outstanding.
//  Simultaneous cache_req and non-empty queue in IDLE: the write is served first.
//   cache_req stays pending until the queue drains.
//  wr_pending = queue not empty OR state in {WR_CMD, WR_HI, WR_LO}.
// STRUCTURE
//  Shared package: FSM state localparams, BURSTLEN, and the halfword-order constant (high half first).
//  One sub-module: cache_sdram_wrfifo (sync FIFO of {addr[31:2], data, bytesel};
//   outputs full/empty/head; ports push, pop).
//  The FSM and burst counter live in the top module.
// TESTING
//  1. Single store 0x1000 / 0xDEADBEEF / bytesel 4'b1111:
//     -> WR_CMD addr 0x1000, then halfwords 0xDEAD dqm 00 and 0xBEEF dqm 00; wr_pending falls.
//  2. Store bytesel 4'b0010 at 0x2004:
//     -> halfwords carry dqm 2'b11 then 2'b01; sd_addr=0x2004.
//  3. Fill at 0x300C, controller returns 0x0001..0x0008:
//     -> data_to_cache 0x0001..0x0008 on 8 consecutive cycles, 1 cycle after each sd_rvalid;
//        cache_fill high only with 0x0001.
//  4. Five back-to-back stores with sd_ack held off:
//     -> 4 wr_ack pulses; 5th acked only after first pop; order preserved.
//  5. Queue 2 stores, assert cache_req in the same cycle:
//     -> both writes complete (WR_LO exits) before the RD_CMD sd_req rises.
//  6. reset low during beat 4 of a burst:
//     -> all outputs at reset values immediately; after release IDLE, no cache_fill.
//     Separately, a 1-cycle sd_rvalid gap -> burst_error=1, still exactly 8 beats delivered.

Source files
------------

// File: rtl/cache_sdram_bridge_pkg.sv
// Shared types and constants for the cache-to-SDRAM bridge: FSM encodings,
// burst geometry, halfword ordering and the write-queue entry layout.
package cache_sdram_bridge_pkg;

  localparam int unsigned BURSTLEN = 8;
  localparam int unsigned BEAT_W   = 3;

  // Store halfwords go out high half first, matching the fill order.
  localparam logic HI_FIRST = 1'b1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR_CMD   = 3'd1;
  localparam logic [2:0] ST_WR_HI    = 3'd2;
  localparam logic [2:0] ST_WR_LO    = 3'd3;
  localparam logic [2:0] ST_RD_CMD   = 3'd4;
  localparam logic [2:0] ST_RD_BURST = 3'd5;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  bytesel;
  } wrq_entry_t;

  // Returns {dqm, halfword} for the first (second=0) or second data phase of a store.
  function automatic logic [17:0] wr_half(input wrq_entry_t e, input logic second);
    logic upper;
    upper = second ^ HI_FIRST;
    return upper ? {~e.bytesel[3:2], e.data[31:16]} : {~e.bytesel[1:0], e.data[15:0]};
  endfunction

endpackage

// File: rtl/cache_sdram_wrfifo.sv
// Synchronous write-through store queue; push and pop may coincide, even when full.
module cache_sdram_wrfifo
  import cache_sdram_bridge_pkg::*;
#(
  parameter int unsigned WRQ_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  wrq_entry_t          din,
  output logic                full,
  output logic                empty,
  output logic [WRQ_LOG2:0]   level,
  output wrq_entry_t          head
);

  localparam int unsigned DEPTH = 1 << WRQ_LOG2;
  localparam int unsigned PW    = WRQ_LOG2;
  localparam int unsigned CW    = WRQ_LOG2 + 1;

  wrq_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_d;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = level;
    case ({do_push, do_pop})
      2'b10:   count_d = level + CW'(1);
      2'b01:   count_d = level - CW'(1);
      default: count_d = level;
    endcase
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/cache_sdram_bridge.sv
// Bridge between the direct-mapped cache and the SDRAM controller: queues
// stores, splits them into halfword writes, and drains them before any line fill.
module cache_sdram_bridge
  import cache_sdram_bridge_pkg::*;
#(
  parameter int unsigned WRQ_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cache_addr,
  input  logic        cache_req,
  output logic [15:0] data_to_cache,
  output logic        cache_fill,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_bytesel,
  input  logic        wr_req,
  output logic        wr_ack,
  output logic        wr_pending,
  output logic [31:0] sd_addr,
  output logic        sd_req,
  output logic        sd_wr,
  input  logic        sd_ack,
  output logic [15:0] sd_wdata,
  output logic [1:0]  sd_dqm,
  input  logic        sd_wnext,
  input  logic [15:0] sd_rdata,
  input  logic        sd_rvalid,
  output logic        burst_error
);

  localparam int unsigned CW = WRQ_LOG2 + 1;

  logic [2:0]        state, state_d;
  logic [BEAT_W-1:0] beat, beat_d;
  logic              q_full, q_empty;
  logic [CW-1:0]     q_level;
  wrq_entry_t        q_head, q_din;
  logic              push, pop;

  logic        sd_req_d, sd_wr_d, cache_fill_d, burst_error_d, wr_pending_d;
  logic [31:0] sd_addr_d;
  logic [15:0] sd_wdata_d, data_to_cache_d;
  logic [1:0]  sd_dqm_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cache_addr[1:0], wr_addr[1:0]};

  // A held wr_req is ignored during its ack cycle so each ack maps to one entry.
  assign pop   = (state == ST_WR_LO) && sd_wnext;
  assign push  = wr_req && !wr_ack && (!q_full || pop);
  assign q_din = '{addr: wr_addr[31:2], data: wr_data, bytesel: wr_bytesel};

  cache_sdram_wrfifo #(.WRQ_LOG2(WRQ_LOG2)) u_wrfifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (q_din),
    .full  (q_full),
    .empty (q_empty),
    .level (q_level),
    .head  (q_head)
  );

  always_comb begin
    state_d         = state;
    beat_d          = beat;
    sd_req_d        = 1'b0;
    sd_wr_d         = 1'b0;
    sd_addr_d       = sd_addr;
    sd_wdata_d      = sd_wdata;
    sd_dqm_d        = 2'b11;
    data_to_cache_d = data_to_cache;
    cache_fill_d    = 1'b0;
    burst_error_d   = burst_error;
    wr_pending_d    = 1'b0;

    // A store being accepted this cycle also holds off a fill.
    case (state)
      ST_IDLE: begin
        if (!q_empty)               state_d = ST_WR_CMD;
        else if (cache_req && !push) state_d = ST_RD_CMD;
      end
      ST_WR_CMD: if (sd_ack)   state_d = ST_WR_HI;
      ST_WR_HI:  if (sd_wnext) state_d = ST_WR_LO;
      ST_WR_LO:  if (sd_wnext) state_d = ST_IDLE;
      ST_RD_CMD: begin
        if (sd_ack) begin
          state_d = ST_RD_BURST;
          beat_d  = '0;
        end
      end
      ST_RD_BURST: begin
        if (sd_rvalid) begin
          data_to_cache_d = sd_rdata;
          cache_fill_d    = (beat == '0);
          beat_d          = beat + BEAT_W'(1);
          if (beat == BEAT_W'(BURSTLEN - 1)) state_d = ST_IDLE;
        end else if (beat != '0) begin
          burst_error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered command/data outputs follow the state being entered.
    case (state_d)
      ST_WR_CMD: begin
        sd_req_d  = 1'b1;
        sd_wr_d   = 1'b1;
        sd_addr_d = {q_head.addr, 2'b00};
      end
      ST_WR_HI: begin
        sd_wr_d                = 1'b1;
        {sd_dqm_d, sd_wdata_d} = wr_half(q_head, 1'b0);
      end
      ST_WR_LO: begin
        sd_wr_d                = 1'b1;
        {sd_dqm_d, sd_wdata_d} = wr_half(q_head, 1'b1);
      end
      ST_RD_CMD: begin
        sd_req_d  = 1'b1;
        sd_addr_d = {cache_addr[31:2], 2'b00};
      end
      default: ;
    endcase

    wr_pending_d = (state_d == ST_WR_CMD) || (state_d == ST_WR_HI) || (state_d == ST_WR_LO) ||
                   push || (q_level != CW'(pop));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      beat          <= '0;
      sd_req        <= 1'b0;
      sd_wr         <= 1'b0;
      sd_addr       <= '0;
      sd_wdata      <= '0;
      sd_dqm        <= 2'b11;
      data_to_cache <= '0;
      cache_fill    <= 1'b0;
      burst_error   <= 1'b0;
      wr_ack        <= 1'b0;
      wr_pending    <= 1'b0;
    end else begin
      state         <= state_d;
      beat          <= beat_d;
      sd_req        <= sd_req_d;
      sd_wr         <= sd_wr_d;
      sd_addr       <= sd_addr_d;
      sd_wdata      <= sd_wdata_d;
      sd_dqm        <= sd_dqm_d;
      data_to_cache <= data_to_cache_d;
      cache_fill    <= cache_fill_d;
      burst_error   <= burst_error_d;
      wr_ack        <= push;
      wr_pending    <= wr_pending_d;
    end
  end

endmodule

// File: tb/tb_cache_sdram_bridge.sv
// Directed bench for cache_sdram_bridge: stores, fills, queue backpressure,
// write-before-fill ordering, burst gaps and reset mid-burst.
module tb_cache_sdram_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] cache_addr;
  logic        cache_req;
  logic [15:0] data_to_cache;
  logic        cache_fill;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_bytesel;
  logic        wr_req;
  logic        wr_ack;
  logic        wr_pending;
  logic [31:0] sd_addr;
  logic        sd_req;
  logic        sd_wr;
  logic        sd_ack;
  logic [15:0] sd_wdata;
  logic [1:0]  sd_dqm;
  logic        sd_wnext;
  logic [15:0] sd_rdata;
  logic        sd_rvalid;
  logic        burst_error;

  int total;
  int bad;

  logic [15:0] cap_data [16];
  logic        cap_fill [16];
  int          cap_n;
  int          fill_cnt;

  cache_sdram_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .cache_addr    (cache_addr),
    .cache_req     (cache_req),
    .data_to_cache (data_to_cache),
    .cache_fill    (cache_fill),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_bytesel    (wr_bytesel),
    .wr_req        (wr_req),
    .wr_ack        (wr_ack),
    .wr_pending    (wr_pending),
    .sd_addr       (sd_addr),
    .sd_req        (sd_req),
    .sd_wr         (sd_wr),
    .sd_ack        (sd_ack),
    .sd_wdata      (sd_wdata),
    .sd_dqm        (sd_dqm),
    .sd_wnext      (sd_wnext),
    .sd_rdata      (sd_rdata),
    .sd_rvalid     (sd_rvalid),
    .burst_error   (burst_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus helpers: drive and record only; the scenario tasks judge the results.
  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] bs,
                            output bit acked);
    wr_addr = a; wr_data = d; wr_bytesel = bs; wr_req = 1'b1; acked = 1'b0;
    for (int n = 0; n < 20 && !acked; n++) begin
      @(negedge clk);
      acked = wr_ack;
    end
    wr_req = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (!sd_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = sd_req;
  endtask

  task automatic serve_write(output logic [31:0] a, output logic wf,
                             output logic [15:0] hi, output logic [1:0] mhi,
                             output logic [15:0] lo, output logic [1:0] mlo, output bit ok);
    a = '0; wf = 1'b0; hi = '0; mhi = '0; lo = '0; mlo = '0;
    wait_req(ok);
    if (ok) begin
      a = sd_addr; wf = sd_wr;
      sd_ack = 1'b1;
      @(negedge clk);
      sd_ack = 1'b0;
      hi = sd_wdata; mhi = sd_dqm;
      sd_wnext = 1'b1;
      @(negedge clk);
      lo = sd_wdata; mlo = sd_dqm;
      @(negedge clk);
      sd_wnext = 1'b0;
    end
  endtask

  task automatic drive_burst(input int gap_at);
    int  beat;
    logic prev_v;
    beat = 0; prev_v = 1'b0; cap_n = 0; fill_cnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (prev_v) begin
        cap_data[cap_n] = data_to_cache;
        cap_fill[cap_n] = cache_fill;
        cap_n++;
      end
      if (cache_fill) fill_cnt++;
      if (beat < 8 && cyc != gap_at) begin
        sd_rvalid = 1'b1;
        sd_rdata  = 16'(beat + 1);
        beat++;
      end else begin
        sd_rvalid = 1'b0;
      end
      prev_v = sd_rvalid;
      @(negedge clk);
    end
    sd_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({sd_req, sd_wr, wr_ack, cache_fill, burst_error, wr_pending} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {sd_req, sd_wr, wr_ack, cache_fill, burst_error, wr_pending});
    end
    total++;
    if (sd_dqm !== 2'b11) begin bad++; $display("FAIL reset_dqm: got %b want 11", sd_dqm); end
    total++;
    if ({data_to_cache, sd_wdata} !== 32'h0) begin
      bad++; $display("FAIL reset_data: got %h want 00000000", {data_to_cache, sd_wdata});
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (sd_req !== 1'b0) begin bad++; $display("FAIL idle_after_reset: sd_req got %b want 0", sd_req); end
  endtask

  task automatic test_single_store();
    bit acked, ok;
    logic [31:0] a; logic wf; logic [15:0] hi, lo; logic [1:0] mhi, mlo;
    push_store(32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, acked);
    total++;
    if (!acked) begin bad++; $display("FAIL store1_ack: got 0 want 1"); end
    total++;
    if (wr_pending !== 1'b1) begin bad++; $display("FAIL store1_pending: got %b want 1", wr_pending); end
    serve_write(a, wf, hi, mhi, lo, mlo, ok);
    total++;
    if (!ok || wf !== 1'b1 || a !== 32'h0000_1000) begin
      bad++; $display("FAIL store1_cmd: got ok=%0d wr=%b addr=%h want 1 1 00001000", ok, wf, a);
    end
    total++;
    if ({hi, mhi, lo, mlo} !== {16'hDEAD, 2'b00, 16'hBEEF, 2'b00}) begin
      bad++; $display("FAIL store1_data: got %h/%b %h/%b want dead/00 beef/00", hi, mhi, lo, mlo);
    end
    total++;
    if (wr_pending !== 1'b0) begin bad++; $display("FAIL store1_pending_fall: got %b want 0", wr_pending); end
  endtask

  task automatic test_partial_store();
    bit acked, ok;
    logic [31:0] a; logic wf; logic [15:0] hi, lo; logic [1:0] mhi, mlo;
    push_store(32'h0000_2004, 32'h1234_5678, 4'b0010, acked);
    serve_write(a, wf, hi, mhi, lo, mlo, ok);
    total++;
    if (!acked || !ok || a !== 32'h0000_2004) begin
      bad++; $display("FAIL store2_addr: got ack=%0d ok=%0d addr=%h want 1 1 00002004", acked, ok, a);
    end
    total++;
    if ({hi, mhi, lo, mlo} !== {16'h1234, 2'b11, 16'h5678, 2'b01}) begin
      bad++; $display("FAIL store2_dqm: got %h/%b %h/%b want 1234/11 5678/01", hi, mhi, lo, mlo);
    end
  endtask

  task automatic test_fill();
    bit ok;
    logic [16:0] got, exp;
    cache_addr = 32'h0000_300C; cache_req = 1'b1;
    wait_req(ok);
    total++;
    if (!ok || sd_wr !== 1'b0 || sd_addr !== 32'h0000_300C) begin
      bad++; $display("FAIL fill_cmd: got ok=%0d wr=%b addr=%h want 1 0 0000300c", ok, sd_wr, sd_addr);
    end
    sd_ack = 1'b1;
    @(negedge clk);
    sd_ack = 1'b0; cache_req = 1'b0;
    total++;
    if (sd_req !== 1'b0) begin bad++; $display("FAIL fill_req_drop: got %b want 0", sd_req); end
    drive_burst(-1);
    total++;
    if (cap_n != 8) begin bad++; $display("FAIL fill_beats: got %0d want 8", cap_n); end
    for (int i = 0; i < 8 && i < cap_n; i++) begin
      got = {cap_fill[i], cap_data[i]};
      exp = {(i == 0), 16'(i + 1)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL fill_beat%0d: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    bit acked, ok;
    int acks, seen;
    logic [31:0] a; logic wf; logic [15:0] hi, lo; logic [1:0] mhi, mlo;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      push_store(32'h0000_4000 + 32'(i * 4), {16'hA000 + 16'(i), 16'hB000 + 16'(i)}, 4'b1111, acked);
      if (acked) acks++;
    end
    total++;
    if (acks != 4) begin bad++; $display("FAIL b2b_acks: got %0d want 4", acks); end
    wr_addr = 32'h0000_4010; wr_data = 32'hA004_B004; wr_bytesel = 4'b1111; wr_req = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_ack) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL b2b_full_noack: got %0d acks want 0", seen); end
    serve_write(a, wf, hi, mhi, lo, mlo, ok);
    total++;
    if (!ok || a !== 32'h0000_4000 || {hi, lo} !== 32'hA000_B000) begin
      bad++; $display("FAIL b2b_first: got ok=%0d addr=%h data=%h want 1 00004000 a000b000", ok, a, {hi, lo});
    end
    total++;
    if (wr_ack !== 1'b1) begin bad++; $display("FAIL b2b_fifth_ack: got %b want 1", wr_ack); end
    wr_req = 1'b0;
    for (int i = 1; i < 5; i++) begin
      serve_write(a, wf, hi, mhi, lo, mlo, ok);
      total++;
      if (!ok || a !== 32'h0000_4000 + 32'(i * 4) ||
          {hi, lo} !== {16'hA000 + 16'(i), 16'hB000 + 16'(i)}) begin
        bad++; $display("FAIL b2b_order%0d: got ok=%0d addr=%h data=%h", i, ok, a, {hi, lo});
      end
    end
    total++;
    if (wr_pending !== 1'b0) begin bad++; $display("FAIL b2b_drained: got %b want 0", wr_pending); end
  endtask

  task automatic test_write_before_fill();
    bit acked_a, acked_b, ok;
    logic [31:0] a; logic wf; logic [15:0] hi, lo; logic [1:0] mhi, mlo;
    cache_addr = 32'h0000_5000; cache_req = 1'b1;
    push_store(32'h0000_5100, 32'h0102_0304, 4'b1111, acked_a);
    push_store(32'h0000_5200, 32'h0506_0708, 4'b1111, acked_b);
    total++;
    if (!acked_a || !acked_b) begin bad++; $display("FAIL wbf_acks: got %0d%0d want 11", acked_a, acked_b); end
    serve_write(a, wf, hi, mhi, lo, mlo, ok);
    total++;
    if (!ok || wf !== 1'b1 || a !== 32'h0000_5100) begin
      bad++; $display("FAIL wbf_first_write: got ok=%0d wr=%b addr=%h want 1 1 00005100", ok, wf, a);
    end
    serve_write(a, wf, hi, mhi, lo, mlo, ok);
    total++;
    if (!ok || wf !== 1'b1 || a !== 32'h0000_5200) begin
      bad++; $display("FAIL wbf_second_write: got ok=%0d wr=%b addr=%h want 1 1 00005200", ok, wf, a);
    end
    wait_req(ok);
    total++;
    if (!ok || sd_wr !== 1'b0 || sd_addr !== 32'h0000_5000) begin
      bad++; $display("FAIL wbf_read: got ok=%0d wr=%b addr=%h want 1 0 00005000", ok, sd_wr, sd_addr);
    end
    sd_ack = 1'b1;
    @(negedge clk);
    sd_ack = 1'b0; cache_req = 1'b0;
    drive_burst(-1);
    total++;
    if (fill_cnt != 1 || cap_n != 8) begin
      bad++; $display("FAIL wbf_burst: got fills=%0d beats=%0d want 1 8", fill_cnt, cap_n);
    end
  endtask

  task automatic test_burst_gap();
    bit ok;
    cache_addr = 32'h0000_7000; cache_req = 1'b1;
    wait_req(ok);
    sd_ack = 1'b1;
    @(negedge clk);
    sd_ack = 1'b0; cache_req = 1'b0;
    total++;
    if (burst_error !== 1'b0) begin bad++; $display("FAIL gap_pre: burst_error got %b want 0", burst_error); end
    drive_burst(3);
    total++;
    if (burst_error !== 1'b1) begin bad++; $display("FAIL gap_error: got %b want 1", burst_error); end
    total++;
    if (!ok || cap_n != 8 || fill_cnt != 1) begin
      bad++; $display("FAIL gap_beats: got ok=%0d beats=%0d fills=%0d want 1 8 1", ok, cap_n, fill_cnt);
    end
    for (int i = 0; i < 8 && i < cap_n; i++) begin
      total++;
      if (cap_data[i] !== 16'(i + 1)) begin
        bad++; $display("FAIL gap_beat%0d: got %h want %h", i, cap_data[i], 16'(i + 1));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int stray;
    cache_addr = 32'h0000_6000; cache_req = 1'b1;
    wait_req(ok);
    sd_ack = 1'b1;
    @(negedge clk);
    sd_ack = 1'b0; cache_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sd_rvalid = 1'b1; sd_rdata = 16'(k + 1);
      @(negedge clk);
    end
    sd_rvalid = 1'b1; sd_rdata = 16'h0004;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({sd_req, sd_wr, wr_ack, cache_fill, burst_error, wr_pending} !== 6'b0) begin
      bad++; $display("FAIL midrst_ctrl: got %b want 000000",
                      {sd_req, sd_wr, wr_ack, cache_fill, burst_error, wr_pending});
    end
    total++;
    if ({data_to_cache, sd_wdata, sd_dqm} !== {16'h0, 16'h0, 2'b11}) begin
      bad++; $display("FAIL midrst_data: got %h %h %b want 0000 0000 11", data_to_cache, sd_wdata, sd_dqm);
    end
    sd_rvalid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (sd_req || cache_fill) stray++;
    end
    total++;
    if (!ok || stray != 0) begin
      bad++; $display("FAIL midrst_idle: got ok=%0d stray=%0d want 1 0", ok, stray);
    end
  endtask

  initial begin
    total = 0; bad = 0; cap_n = 0; fill_cnt = 0;
    reset = 1'b0;
    cache_addr = '0; cache_req = 1'b0;
    wr_addr = '0; wr_data = '0; wr_bytesel = '0; wr_req = 1'b0;
    sd_ack = 1'b0; sd_wnext = 1'b0; sd_rdata = '0; sd_rvalid = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_store();
    test_partial_store();
    test_fill();
    test_back_to_back();
    test_write_before_fill();
    test_burst_gap();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
